// File: rtl/tdm_demux4_if.sv
// Shared-line TDM link between the mux-side serializer and the 4-channel demux.
// The master drives the sample line and reads back the decoded channels.
// The slave (demux) receives samples and drives the channel outputs.
interface tdm_demux4_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    logic             q_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  q0, q1, q2, q3, q_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output q0, q1, q2, q3, q_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// 4-channel TDM receiver: locks on frame_sync, stages slots 0..2 and updates
// all four channel outputs together when the slot-3 sample is accepted.
// Optional mid-frame idle timeout enabled by defining TDM_TIMEOUT_EN.
module tdm_demux4 #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    tdm_demux4_if.slave       bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_stage0;
    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;
    logic [WIDTH-1:0] r_q0;
    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;
    logic [WIDTH-1:0] r_q3;
    logic             r_q_valid;
    logic [1:0]       r_slot;
    logic             r_sync_err;
    logic             w_accept;

    // A zero timeout would unlock a frame before it could ever advance
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("tdm_demux4: TIMEOUT must be at least 1");
    end

`ifdef TDM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_idle_cnt;
`endif

    assign w_accept = bus.din_valid;

    // Frame alignment FSM, staging buffer and registered channel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_stage0   <= '0;
            r_stage1   <= '0;
            r_stage2   <= '0;
            r_q0       <= '0;
            r_q1       <= '0;
            r_q2       <= '0;
            r_q3       <= '0;
            r_q_valid  <= 1'b0;
            r_slot     <= 2'd0;
            r_sync_err <= 1'b0;
`ifdef TDM_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
        end else begin
            r_q_valid  <= 1'b0;
            r_sync_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef TDM_TIMEOUT_EN
                    r_idle_cnt <= '0;
`endif
                    if (w_accept && bus.frame_sync) begin
                        r_stage0 <= bus.din;
                        r_slot   <= 2'd1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
`ifdef TDM_TIMEOUT_EN
                        r_idle_cnt <= '0;
`endif
                        if (bus.frame_sync) begin
                            // Sync mid-frame means misalignment: drop partial frame and realign
                            r_sync_err <= (r_slot != 2'd0);
                            r_stage0   <= bus.din;
                            r_slot     <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd0: r_stage0 <= bus.din;
                                2'd1: r_stage1 <= bus.din;
                                2'd2: r_stage2 <= bus.din;
                                default: begin
                                    r_q0      <= r_stage0;
                                    r_q1      <= r_stage1;
                                    r_q2      <= r_stage2;
                                    r_q3      <= bus.din;
                                    r_q_valid <= 1'b1;
                                end
                            endcase
                            r_slot <= r_slot + 2'd1;
                        end
                    end
`ifdef TDM_TIMEOUT_EN
                    else if (r_slot != 2'd0) begin
                        // Stalled mid-frame too long: give up the lock
                        if (r_idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_sync_err <= 1'b1;
                            r_slot     <= 2'd0;
                            r_idle_cnt <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                        end
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_slot  <= 2'd0;
                end
            endcase
        end
    end

    assign bus.q0       = r_q0;
    assign bus.q1       = r_q1;
    assign bus.q2       = r_q2;
    assign bus.q3       = r_q3;
    assign bus.q_valid  = r_q_valid;
    assign bus.slot     = r_slot;
    assign bus.locked   = (r_state == S_RUN);
    assign bus.sync_err = r_sync_err;
endmodule
